// File: rtl/edge_counter_pkg.sv
// Shared definitions for edge_counter: filter FSM state encodings and stable-counter width.
package edge_counter_pkg;

  localparam int FCNT_W = 4;

  typedef enum logic [1:0] {
    ST_LO    = 2'd0,
    ST_LO2HI = 2'd1,
    ST_HI    = 2'd2,
    ST_HI2LO = 2'd3
  } filt_state_t;

endpackage

// File: rtl/edge_filter.sv
// Glitch filter on a single registered bit: a level change is accepted after FILT+1
// consecutive stable samples, and a one-cycle rise/fall pulse is emitted on acceptance.
module edge_filter #(
  parameter int FILT = 3
) (
  input  logic c,
  input  logic rstn,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  import edge_counter_pkg::*;

  localparam logic [FCNT_W-1:0] FILT_C   = FCNT_W'(FILT);
  localparam logic [FCNT_W-1:0] FCNT_ONE = FCNT_W'(1);

  filt_state_t       state_reg, state_next;
  logic [FCNT_W-1:0] fcnt_reg, fcnt_next;
  logic              rise_reg, rise_next;
  logic              fall_reg, fall_next;

  always_ff @(posedge c or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_LO;
      fcnt_reg  <= '0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      fcnt_reg  <= fcnt_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    fcnt_next  = fcnt_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      ST_LO: begin
        if (d) begin
          if (FILT == 0) begin
            state_next = ST_HI;
            rise_next  = 1'b1;
          end else begin
            state_next = ST_LO2HI;
            fcnt_next  = FCNT_ONE;
          end
        end
      end
      ST_LO2HI: begin
        if (!d) begin
          state_next = ST_LO;
          fcnt_next  = '0;
        end else if (fcnt_reg == FILT_C) begin
          state_next = ST_HI;
          fcnt_next  = '0;
          rise_next  = 1'b1;
        end else begin
          fcnt_next = fcnt_reg + FCNT_ONE;
        end
      end
      ST_HI: begin
        if (!d) begin
          if (FILT == 0) begin
            state_next = ST_LO;
            fall_next  = 1'b1;
          end else begin
            state_next = ST_HI2LO;
            fcnt_next  = FCNT_ONE;
          end
        end
      end
      ST_HI2LO: begin
        if (d) begin
          state_next = ST_HI;
          fcnt_next  = '0;
        end else if (fcnt_reg == FILT_C) begin
          state_next = ST_LO;
          fcnt_next  = '0;
          fall_next  = 1'b1;
        end else begin
          fcnt_next = fcnt_reg + FCNT_ONE;
        end
      end
      default: begin
        state_next = ST_LO;
        fcnt_next  = '0;
      end
    endcase
  end

  // Level is taken straight from the state register, so it stays glitch-free.
  assign level = (state_reg == ST_HI) || (state_reg == ST_HI2LO);
  assign rise  = rise_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/edge_counter.sv
// Filtered edge detector with a saturating rise counter whose value is handed out as
// atomic snapshots over a valid/ready handshake.
module edge_counter #(
  parameter int WIDTH = 8,
  parameter int FILT  = 3
) (
  input  logic             c,
  input  logic             rstn,
  input  logic             d,
  input  logic             clr,
  input  logic             rd_req,
  input  logic             cnt_rdy,
  output logic [WIDTH-1:0] cnt_o,
  output logic             cnt_vld,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic             sat
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] cnt_o_reg, cnt_o_next;
  logic             vld_reg, vld_next;
  logic             sat_reg, sat_next;
  logic             snap;

  edge_filter #(.FILT(FILT)) u_filter (
    .c     (c),
    .rstn  (rstn),
    .d     (d),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // A request is only honoured while no snapshot is outstanding.
  assign snap = rd_req && !vld_reg;

  always_comb begin
    cnt_next   = cnt_reg;
    cnt_o_next = cnt_o_reg;
    vld_next   = vld_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (snap) begin
      // A rise landing on the snapshot edge seeds the fresh count so it is not lost.
      cnt_next = rise ? CNT_ONE : '0;
    end else if (rise && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + CNT_ONE;
    end
    sat_next = (clr || snap) ? 1'b0 : (sat_reg || (cnt_next == CNT_MAX));
    if (snap) begin
      cnt_o_next = cnt_reg;
      vld_next   = 1'b1;
    end else if (vld_reg && cnt_rdy) begin
      vld_next = 1'b0;
    end
  end

  always_ff @(posedge c or negedge rstn) begin
    if (!rstn) begin
      cnt_reg   <= '0;
      cnt_o_reg <= '0;
      vld_reg   <= 1'b0;
      sat_reg   <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      cnt_o_reg <= cnt_o_next;
      vld_reg   <= vld_next;
      sat_reg   <= sat_next;
    end
  end

  assign cnt_o   = cnt_o_reg;
  assign cnt_vld = vld_reg;
  assign sat     = sat_reg;

endmodule

// File: tb/tb_edge_counter.sv
// Bench for edge_counter: three parameterisations share one stimulus stream and are
// checked every cycle against a run-length / event-count reference model.
module tb_edge_counter;

  localparam int NINST = 3;

  logic c;
  logic rstn;
  logic d;
  logic clr;
  logic rd_req;
  logic cnt_rdy;

  logic [NINST-1:0] vld_o, level_o, rise_o, fall_o, sat_o;
  logic [31:0]      cnt_o_a [NINST];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state per instance.
  bit m_level [NINST];
  bit m_rise  [NINST];
  bit m_fall  [NINST];
  bit m_sat   [NINST];
  bit m_vld   [NINST];
  int m_run   [NINST];
  int m_cnt   [NINST];
  int m_cnto  [NINST];

  function automatic int p_w(input int i);
    return (i == 2) ? 2 : 8;
  endfunction

  function automatic int p_f(input int i);
    return (i == 0) ? 3 : 0;
  endfunction

  for (genvar gi = 0; gi < NINST; gi++) begin : g_dut
    localparam int W = (gi == 2) ? 2 : 8;
    localparam int F = (gi == 0) ? 3 : 0;
    logic [W-1:0] co;
    edge_counter #(.WIDTH(W), .FILT(F)) u_dut (
      .c       (c),
      .rstn    (rstn),
      .d       (d),
      .clr     (clr),
      .rd_req  (rd_req),
      .cnt_rdy (cnt_rdy),
      .cnt_o   (co),
      .cnt_vld (vld_o[gi]),
      .level   (level_o[gi]),
      .rise    (rise_o[gi]),
      .fall    (fall_o[gi]),
      .sat     (sat_o[gi])
    );
    assign cnt_o_a[gi] = 32'(co);
  end

  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NINST; i++) begin
      m_level[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_sat[i] = 0;
      m_vld[i] = 0; m_run[i] = 0; m_cnt[i] = 0; m_cnto[i] = 0;
    end
  endtask

  // One clock edge of the reference: a level flips after FILT+1 consecutive samples
  // that disagree with it; the count reacts to the previous cycle's rise pulse.
  task automatic model_step();
    for (int i = 0; i < NINST; i++) begin
      int max_v;
      bit prev_rise;
      bit snap;
      max_v     = (1 << p_w(i)) - 1;
      prev_rise = m_rise[i];
      snap      = rd_req && !m_vld[i];
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (d != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == p_f(i) + 1) begin
          m_level[i] = d;
          m_run[i]   = 0;
          if (d) m_rise[i] = 1;
          else   m_fall[i] = 1;
        end
      end else begin
        m_run[i] = 0;
      end
      if (m_vld[i] && cnt_rdy) begin
        $display("xfer inst%0d cnt_o=%0d", i, m_cnto[i]);
        m_vld[i] = 0;
      end
      if (snap) begin
        m_cnto[i] = m_cnt[i];
        m_vld[i]  = 1;
      end
      if (clr)                             m_cnt[i] = 0;
      else if (snap)                       m_cnt[i] = prev_rise ? 1 : 0;
      else if (prev_rise && m_cnt[i] < max_v) m_cnt[i] = m_cnt[i] + 1;
      if (clr || snap)             m_sat[i] = 0;
      else if (m_cnt[i] == max_v)  m_sat[i] = 1;
    end
  endtask

  always @(posedge c) begin
    if (rstn) model_step();
  end

  task automatic compare_all();
    for (int i = 0; i < NINST; i++) begin
      check_value($sformatf("level%0d", i), 32'(level_o[i]), 32'(m_level[i]));
      check_value($sformatf("rise%0d", i),  32'(rise_o[i]),  32'(m_rise[i]));
      check_value($sformatf("fall%0d", i),  32'(fall_o[i]),  32'(m_fall[i]));
      check_value($sformatf("sat%0d", i),   32'(sat_o[i]),   32'(m_sat[i]));
      check_value($sformatf("vld%0d", i),   32'(vld_o[i]),   32'(m_vld[i]));
      check_value($sformatf("cnto%0d", i),  cnt_o_a[i],      32'(m_cnto[i]));
    end
  endtask

  task automatic step();
    @(posedge c);
    @(negedge c);
    compare_all();
  endtask

  task automatic pulse();
    d = 1'b1; step(); step();
    d = 1'b0; step(); step();
  endtask

  task automatic snap_check(input int i, input int exp);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    check_value($sformatf("snap_cnt%0d", i), cnt_o_a[i], 32'(exp));
    cnt_rdy = 1'b1; step(); cnt_rdy = 1'b0;
  endtask

  initial begin
    int hold;
    rstn = 1'b0; d = 1'b0; clr = 1'b0; rd_req = 1'b0; cnt_rdy = 1'b0;
    model_reset();

    // Reset held while d toggles
    for (int k = 0; k < 6; k++) begin
      d = ~d;
      step();
    end
    check_value("rst_vld", 32'(vld_o), 32'd0);
    check_value("rst_level", 32'(level_o), 32'd0);

    // FILT=3 acceptance after the 4th stable sample
    @(negedge c);
    rstn = 1'b1; d = 1'b1;
    step(); step(); step();
    check_value("rise_early", 32'(rise_o[0]), 32'd0);
    step();
    check_value("rise_filt3", 32'(rise_o[0]), 32'd1);
    check_value("level_filt3", 32'(level_o[0]), 32'd1);
    step();
    check_value("rise_width", 32'(rise_o[0]), 32'd0);

    // Glitch rejection on the FILT=3 instance
    d = 1'b0;
    repeat (6) step();
    snap_check(0, 1);
    d = 1'b1; step(); step(); step();
    d = 1'b0; repeat (4) step();
    check_value("glitch_level", 32'(level_o[0]), 32'd0);
    snap_check(0, 0);
    snap_check(1, 0);

    // Five clean pulses, snapshot held while consumer stalls
    repeat (5) pulse();
    check_value("sat_w2", 32'(sat_o[2]), 32'd1);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    check_value("snap5_vld", 32'(vld_o[1]), 32'd1);
    check_value("snap5_cnt", cnt_o_a[1], 32'd5);
    check_value("snap_sat_cnt", cnt_o_a[2], 32'd3);
    repeat (3) begin
      step();
      check_value("hold_vld", 32'(vld_o[1]), 32'd1);
      check_value("hold_cnt", cnt_o_a[1], 32'd5);
    end
    cnt_rdy = 1'b1; step(); cnt_rdy = 1'b0;
    check_value("xfer_drop", 32'(vld_o[1]), 32'd0);
    snap_check(1, 0);

    // Saturation then clear
    repeat (4) pulse();
    check_value("sat_set", 32'(sat_o[2]), 32'd1);
    clr = 1'b1; step(); clr = 1'b0;
    check_value("sat_clr", 32'(sat_o[2]), 32'd0);
    snap_check(2, 0);

    // Rise coincident with snapshot
    pulse(); pulse();
    d = 1'b1; step();
    check_value("rise_vis", 32'(rise_o[1]), 32'd1);
    rd_req = 1'b1; step(); rd_req = 1'b0;
    check_value("rise_snap_old", cnt_o_a[1], 32'd2);
    cnt_rdy = 1'b1; step(); cnt_rdy = 1'b0;
    d = 1'b0; step(); step();
    snap_check(1, 1);

    // Rise coincident with clear
    pulse();
    d = 1'b1; step();
    check_value("rise_vis2", 32'(rise_o[1]), 32'd1);
    clr = 1'b1; step(); clr = 1'b0;
    d = 1'b0; step(); step();
    snap_check(1, 0);

    // Randomized traffic
    hold = 0;
    for (int k = 0; k < 3000; k++) begin
      if (hold == 0) begin
        d    = ~d;
        hold = $urandom_range(1, 6);
      end
      hold--;
      clr     = ($urandom_range(0, 31) == 0);
      rd_req  = ($urandom_range(0, 5) == 0);
      cnt_rdy = ($urandom_range(0, 2) != 0);
      step();
    end
    clr = 1'b0; rd_req = 1'b0; cnt_rdy = 1'b0;

    // Reset mid-handshake and mid-filter
    d = 1'b0; repeat (6) step();
    rd_req = 1'b1; step(); rd_req = 1'b0;
    d = 1'b1; step();
    check_value("pre_rst_vld", 32'(vld_o[1]), 32'd1);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    check_value("async_vld", 32'(vld_o), 32'd0);
    check_value("async_level", 32'(level_o), 32'd0);
    check_value("async_rise", 32'(rise_o | fall_o | sat_o), 32'd0);
    check_value("async_cnt0", cnt_o_a[0], 32'd0);
    check_value("async_cnt1", cnt_o_a[1], 32'd0);
    rstn = 1'b1;
    @(negedge c);
    compare_all();
    step(); step();
    check_value("post_rst_early", 32'(rise_o[0]), 32'd0);
    step();
    check_value("post_rst_rise", 32'(rise_o[0]), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
